// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
// Processor-wide constants and types shared by the fetch stage:
//   XLEN              - datapath / address width
//   RESET_PC_DEFAULT  - default PC loaded on reset
//   TIMEOUT_DEFAULT   - default number of WAIT cycles before a fetch error
//   INSTR_ALIGN_MASK  - low PC bits that must be zero for a legal fetch
//   fetch_state_e     - fetch FSM state encoding (2 bits)
//   is_aligned()      - instruction-alignment test
package pc_fetch_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned     TIMEOUT_DEFAULT  = 255;
    localparam logic [1:0]      INSTR_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_e;

    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] & INSTR_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if
// Instruction-memory request/response bus.
//   imem_req    - request valid (fetch -> memory)
//   imem_addr   - request address (fetch -> memory)
//   imem_gnt    - request accepted this cycle (memory -> fetch)
//   imem_rvalid - read data valid (memory -> fetch)
//   imem_rdata  - instruction word (memory -> fetch)
// master: fetch unit side, slave: memory side.
interface pc_fetch_if;
    import pc_fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_timer.sv
// fetch_timer
// Wait-cycle watchdog for the fetch FSM. Down-counter loaded with TIMEOUT-1
// while clear is high; decrements on each enabled cycle. expired fires on the
// enabled cycle that would complete TIMEOUT waited cycles.
//   clk, rst - clock, synchronous active-high reset
//   clear    - reload the counter (held while not waiting)
//   enable   - count this cycle (waiting and no response)
//   expired  - terminal count reached on an enabled cycle
module fetch_timer
    import pc_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch
// Instruction fetch stage: issues one request at a time to instruction memory
// at the current PC, captures the returned word, presents pc/op downstream
// until retired, then moves to the next PC. Misaligned next PC or a memory
// response timeout lands in a terminal error state until reset.
//   clk, rst   - clock, synchronous active-high reset
//   imem       - instruction-memory bus (master side)
//   nextpc     - next PC from the next-PC stage
//   inst_valid - pc/op hold a valid fetched instruction
//   inst_ready - downstream retires the current instruction
//   pc, op     - current program counter / instruction word
//   fetch_err  - sticky error flag
//   retired    - retired instruction count (wraps)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_REQ   | request driven at pc, waiting for grant
// ST_WAIT  | request accepted, waiting for rvalid (watchdog running)
// ST_VALID | pc/op valid downstream, waiting for inst_ready
// ST_ERR   | timeout or misaligned next PC; frozen until reset
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_if.master      imem,
    input  logic [XLEN-1:0] nextpc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] op,
    output logic            fetch_err,
    output logic [XLEN-1:0] retired
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] op_q;
    logic [XLEN-1:0] retired_q;
    logic            req_q;
    logic            valid_q;
    logic            err_q;

    logic            tmr_clear;
    logic            tmr_enable;
    logic            tmr_expired;

    assign tmr_clear  = (state_q != ST_WAIT);
    assign tmr_enable = (state_q == ST_WAIT) && !imem.imem_rvalid;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // req_q/valid_q/err_q are updated together with state_q so the outputs
    // come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            op_q      <= '0;
            retired_q <= '0;
            req_q     <= 1'b1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (imem.imem_gnt) begin
                        state_q <= ST_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // A response in the final permitted cycle still wins.
                    if (imem.imem_rvalid) begin
                        op_q    <= imem.imem_rdata;
                        state_q <= ST_VALID;
                        valid_q <= 1'b1;
                    end else if (tmr_expired) begin
                        state_q <= ST_ERR;
                        err_q   <= 1'b1;
                    end
                end
                ST_VALID: begin
                    if (inst_ready) begin
                        pc_q    <= nextpc;
                        valid_q <= 1'b0;
                        if (is_aligned(nextpc)) begin
                            retired_q <= retired_q + 1'b1;
                            state_q   <= ST_REQ;
                            req_q     <= 1'b1;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                end
                default: begin
                    state_q <= ST_ERR;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    // Gate with rst so nothing is requested or presented during a reset cycle.
    assign imem.imem_req  = req_q && !rst;
    assign imem.imem_addr = pc_q;
    assign inst_valid     = valid_q && !rst;
    assign pc             = pc_q;
    assign op             = op_q;
    assign fetch_err      = err_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

    localparam int unsigned TMO  = 8;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    localparam int PH_FETCH = 0;
    localparam int PH_AWAIT = 1;
    localparam int PH_HOLD  = 2;
    localparam int PH_DEAD  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] nextpc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] pc;
    logic [31:0] op;
    logic        fetch_err;
    logic [31:0] retired;

    pc_fetch_if bus ();

    pc_fetch #(
        .RESET_PC (RPC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem       (bus),
        .nextpc     (nextpc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .pc         (pc),
        .op         (op),
        .fetch_err  (fetch_err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: where the fetch is, what it holds, how
    // long it has waited.
    int          m_phase = PH_FETCH;
    int          m_wait  = 0;
    bit          m_known = 1'b0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_op    = '0;
    logic [31:0] m_ret   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = PH_FETCH;
            m_pc    = RPC;
            m_op    = '0;
            m_ret   = '0;
            m_wait  = 0;
            m_known = 1'b1;
        end else begin
            case (m_phase)
                PH_FETCH: if (bus.imem_gnt) begin
                    m_phase = PH_AWAIT;
                    m_wait  = 0;
                end
                PH_AWAIT: if (bus.imem_rvalid) begin
                    m_op    = bus.imem_rdata;
                    m_phase = PH_HOLD;
                end else begin
                    m_wait++;
                    if (m_wait >= int'(TMO)) m_phase = PH_DEAD;
                end
                PH_HOLD: if (inst_ready) begin
                    m_pc = nextpc;
                    if (nextpc % 4 != 0) begin
                        m_phase = PH_DEAD;
                    end else begin
                        m_ret   = m_ret + 1;
                        m_phase = PH_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("m_req",   32'(bus.imem_req), 32'((m_phase == PH_FETCH) && !rst));
            chk("m_addr",  bus.imem_addr, m_pc);
            chk("m_valid", 32'(inst_valid), 32'((m_phase == PH_HOLD) && !rst));
            chk("m_pc",    pc, m_pc);
            chk("m_op",    op, m_op);
            chk("m_err",   32'(fetch_err), 32'(m_phase == PH_DEAD));
            chk("m_ret",   retired, m_ret);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        inst_ready      = 1'b0;
        nextpc          = '0;
    endtask

    bit slow;

    initial begin
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        // Still in reset: nothing requested or presented.
        @(negedge clk);
        chk("rst_req",   32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);

        // Reset release, gnt in first REQ cycle, rvalid in first WAIT cycle.
        step();
        rst = 1'b0;
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        chk("c1_req",  32'(bus.imem_req), 32'd1);
        chk("c1_addr", bus.imem_addr, 32'h0);
        chk("c1_ret",  retired, 32'd0);
        chk("c1_op",   op, 32'd0);
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h2008_0005;
        @(negedge clk);
        chk("c2_req", 32'(bus.imem_req), 32'd0);
        step();
        bus.imem_rvalid = 1'b0;
        nextpc          = 32'h0000_0004;
        inst_ready      = 1'b1;
        @(negedge clk);
        chk("c3_valid", 32'(inst_valid), 32'd1);
        chk("c3_pc",    pc, 32'h0);
        chk("c3_op",    op, 32'h2008_0005);
        step();
        inst_ready = 1'b0;
        @(negedge clk);
        chk("ret_req",  32'(bus.imem_req), 32'd1);
        chk("ret_addr", bus.imem_addr, 32'h4);
        chk("ret_cnt",  retired, 32'd1);

        // gnt withheld 5 cycles in REQ, with stray rvalid that must be ignored.
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("hold_req", 32'(bus.imem_req), 32'd1);
            chk("hold_pc",  pc, 32'h4);
        end
        chk("hold_op", op, 32'h2008_0005);

        // Fetch at 4, then misaligned nextpc 6 -> error.
        step();
        bus.imem_rvalid = 1'b0;
        bus.imem_gnt    = 1'b1;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1111_2222;
        step();
        bus.imem_rvalid = 1'b0;
        nextpc          = 32'h0000_0006;
        inst_ready      = 1'b1;
        step();
        inst_ready      = 1'b0;
        bus.imem_rvalid = 1'b1;
        @(negedge clk);
        chk("mis_err",   32'(fetch_err), 32'd1);
        chk("mis_ret",   retired, 32'd1);
        chk("mis_pc",    pc, 32'h6);
        chk("mis_valid", 32'(inst_valid), 32'd0);
        step();
        bus.imem_rvalid = 1'b0;
        @(negedge clk);
        chk("err_stick", 32'(fetch_err), 32'd1);
        chk("err_op",    op, 32'h1111_2222);

        // Timeout: enter WAIT, withhold rvalid for TMO cycles.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        @(negedge clk);
        chk("to_0", 32'(fetch_err), 32'd0);
        for (int i = 1; i <= int'(TMO); i++) begin
            step();
            @(negedge clk);
            chk("to_err", 32'(fetch_err), 32'(i == int'(TMO)));
            chk("to_req", 32'(bus.imem_req), 32'd0);
        end
        bus.imem_gnt = 1'b1;
        step();
        @(negedge clk);
        chk("to_req_after", 32'(bus.imem_req), 32'd0);
        bus.imem_gnt = 1'b0;

        // Reset mid-WAIT from a non-reset PC, then stray rvalid in first REQ.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0000_0013;
        step();
        bus.imem_rvalid = 1'b0;
        nextpc          = 32'h0000_0040;
        inst_ready      = 1'b1;
        step();
        inst_ready   = 1'b0;
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        @(negedge clk);
        chk("mid_pc", pc, 32'h40);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("rs_req",  32'(bus.imem_req), 32'd1);
        chk("rs_addr", bus.imem_addr, RPC);
        step();
        bus.imem_rvalid = 1'b0;
        @(negedge clk);
        chk("rs_req2",  32'(bus.imem_req), 32'd1);
        chk("rs_valid", 32'(inst_valid), 32'd0);
        chk("rs_op",    op, 32'd0);

        // Randomized traffic, checked every cycle by the model.
        slow = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c % 250 == 0) slow = 1'($urandom_range(1));
            if (m_phase == PH_DEAD) rst = ($urandom_range(7) == 0);
            else                    rst = ($urandom_range(63) == 0);
            bus.imem_gnt    = 1'($urandom_range(1));
            bus.imem_rvalid = slow ? ($urandom_range(19) == 0) : 1'($urandom_range(1));
            bus.imem_rdata  = $urandom();
            inst_ready      = 1'($urandom_range(1));
            case ($urandom_range(15))
                0:                      nextpc = $urandom();
                1, 2, 3, 4, 5, 6, 7, 8: nextpc = m_pc + 32'd4;
                default:                nextpc = $urandom() & 32'hFFFF_FFFC;
            endcase
        end
        step();
        idle_inputs();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
